// File: rtl/imm_fetch_decode_pkg.sv
// Shared types and constants for the immediate fetch/decode stage.
package imm_fetch_decode_pkg;

    localparam int unsigned IMM_W = 12;
    localparam int unsigned FMT_W = 2;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [FMT_W-1:0] {
        FMT_I    = 2'd0,
        FMT_S    = 2'd1,
        FMT_NONE = 2'd2
    } fmt_e;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        fmt_e             fmt;
        logic             illegal;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_field_dec.sv
// Combinational opcode classification and 12-bit immediate extraction.
module imm_field_dec
    import imm_fetch_decode_pkg::*;
#(
    parameter int unsigned INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec_c
);

    // rs1/funct3 bits carry no immediate information here
    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    always_comb begin
        dec_c         = '0;
        dec_c.fmt     = FMT_NONE;
        dec_c.illegal = 1'b1;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_c.imm     = instr[31:20];
                dec_c.fmt     = FMT_I;
                dec_c.illegal = 1'b0;
            end
            OPC_STORE: begin
                dec_c.imm     = {instr[31:25], instr[11:7]};
                dec_c.fmt     = FMT_S;
                dec_c.illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_fetch_decode.sv
// Decode stage feeding the sign extender: 2-entry skid buffer plus delivered-instruction counter.
module imm_fetch_decode
    import imm_fetch_decode_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IMM_W-1:0]   out_imm,
    output logic [FMT_W-1:0]   out_fmt,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   insn_cnt
);

    dec_t       in_dec_c;
    dec_t       out_q;
    dec_t       skid_q;
    buf_state_e state;
    buf_state_e state_next;
    logic       accept;
    logic       fire;
    logic       load_out_in;
    logic       load_out_skid;
    logic       load_skid;

    imm_field_dec #(.INSTR_W(INSTR_W)) u_dec (
        .instr (in_instr),
        .dec_c (in_dec_c)
    );

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (accept) state_next = ST_ONE;
            end
            ST_ONE: begin
                if (accept && !fire)      state_next = ST_FULL;
                else if (!accept && fire) state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (fire) state_next = ST_ONE;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Datapath load controls; FULL never accepts because in_ready is low there
    always_comb begin
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: load_out_in = accept;
            ST_ONE: begin
                load_out_in = accept && fire;
                load_skid   = accept && !fire;
            end
            ST_FULL:  load_out_skid = fire;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            insn_cnt  <= '0;
        end else begin
            if (load_out_in)        out_q <= in_dec_c;
            else if (load_out_skid) out_q <= skid_q;
            if (load_skid)          skid_q <= in_dec_c;
            out_valid <= (state_next != ST_EMPTY);
            in_ready  <= (state_next != ST_FULL);
            if (fire) insn_cnt <= insn_cnt + CNT_W'(1);
        end
    end

    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_fetch_decode.sv
// Directed-vector bench for imm_fetch_decode (counter narrowed to 4 bits to reach wrap quickly).
module tb_imm_fetch_decode;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [11:0]        out_imm;
    logic [1:0]         out_fmt;
    logic               out_illegal;
    logic [CNT_W-1:0]   insn_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    imm_fetch_decode #(.INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .insn_cnt    (insn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [11:0] imm, input logic [1:0] fmt,
                             input logic ill);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_imm"}, 32'(out_imm), 32'(imm));
        check({tag, "_fmt"}, 32'(out_fmt), 32'(fmt));
        check({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    // Single transaction with out_ready=1: accept, then fire on the next edge
    task automatic one_shot(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cnt", 32'(insn_cnt), 32'd0);
        check("rst_imm", 32'(out_imm), 32'd0);
        check("rst_fmt", 32'(out_fmt), 32'd0);
        check("rst_ill", 32'(out_illegal), 32'd0);
        rst = 1'b0;
        tick();

        // addi x1, x0, 5
        in_valid = 1'b1;
        in_instr = 32'h0050_0093;
        tick();
        in_valid = 1'b0;
        check_out("addi", 12'h005, 2'd0, 1'b0);
        check("addi_cnt_before", 32'(insn_cnt), 32'd0);
        tick();
        check("addi_cnt", 32'(insn_cnt), 32'd1);
        check("addi_drained", 32'(out_valid), 32'd0);

        // addi -5 then lw -12 back-to-back
        in_valid = 1'b1;
        in_instr = 32'hFFB0_0093;
        tick();
        check_out("addi_neg", 12'hFFB, 2'd0, 1'b0);
        check("b2b_ready0", 32'(in_ready), 32'd1);
        in_instr = 32'hFF40_2083;
        tick();
        in_valid = 1'b0;
        check_out("lw_neg", 12'hFF4, 2'd0, 1'b0);
        check("b2b_ready1", 32'(in_ready), 32'd1);
        check("b2b_cnt", 32'(insn_cnt), 32'd2);
        tick();
        check("b2b_cnt_end", 32'(insn_cnt), 32'd3);

        // sw -12 then lui (no immediate, still delivered)
        in_valid = 1'b1;
        in_instr = 32'hFE20_AA23;
        tick();
        check_out("sw", 12'hFF4, 2'd1, 1'b0);
        in_instr = 32'h1234_5037;
        tick();
        in_valid = 1'b0;
        check_out("lui", 12'h000, 2'd2, 1'b1);
        tick();
        check("lui_cnt", 32'(insn_cnt), 32'd5);
        check("lui_drained", 32'(out_valid), 32'd0);

        // Backpressure: A,B,C,D with out_ready low for 3 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0010_0093;
        tick();
        check_out("bp_A", 12'h001, 2'd0, 1'b0);
        check("bp_ready_one", 32'(in_ready), 32'd1);
        in_instr = 32'h0020_0093;
        tick();
        check("bp_ready_full", 32'(in_ready), 32'd0);
        check_out("bp_A_hold", 12'h001, 2'd0, 1'b0);
        in_instr = 32'h0030_0093;
        tick();
        check("bp_ready_full2", 32'(in_ready), 32'd0);
        check_out("bp_A_hold2", 12'h001, 2'd0, 1'b0);
        check("bp_cnt_hold", 32'(insn_cnt), 32'd5);
        out_ready = 1'b1;
        tick();
        check_out("bp_B", 12'h002, 2'd0, 1'b0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        check_out("bp_C", 12'h003, 2'd0, 1'b0);
        in_instr = 32'h0040_0093;
        tick();
        in_valid = 1'b0;
        check_out("bp_D", 12'h004, 2'd0, 1'b0);
        tick();
        check("bp_cnt", 32'(insn_cnt), 32'd9);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Counter wrap (4-bit): 9 + 6 = 15, then 0
        for (int i = 0; i < 6; i++) one_shot(32'h0000_0013);
        check("wrap_max", 32'(insn_cnt), 32'd15);
        one_shot(32'h0000_0013);
        check("wrap_zero", 32'(insn_cnt), 32'd0);
        one_shot(32'h0000_0013);
        check("wrap_one", 32'(insn_cnt), 32'd1);

        // Fill to FULL, then assert reset between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00A0_0093;
        tick();
        in_instr = 32'h00B0_0093;
        tick();
        in_valid = 1'b0;
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cnt", 32'(insn_cnt), 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h7FF0_0093;
        tick();
        in_valid = 1'b0;
        check_out("post_rst", 12'h7FF, 2'd0, 1'b0);
        tick();
        check("post_rst_cnt", 32'(insn_cnt), 32'd1);
        check("post_rst_drained", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
